// File: rtl/cache_pkg.sv
// Shared types and block-geometry constants for the cache miss/fill logic.
package cache_pkg;

    typedef enum logic {
        IDLE,
        FILL
    } fill_state_t;

    localparam int WORDS_PER_BLOCK   = 8;
    localparam int BLOCK_OFFSET_BITS = 4;

endpackage : cache_pkg

// File: rtl/cache_fill_fsm_onehot_dec3to8.sv
// 3-to-8 one-hot decoder with enable; shared by word-enable and block-enable decode.
module onehot_dec3to8 (
    input  logic       i_en,
    input  logic [2:0] i_sel,
    output logic [7:0] o_onehot
);

    always_comb begin
        o_onehot = '0;
        if (i_en) begin
            o_onehot[i_sel] = 1'b1;
        end
    end

endmodule : onehot_dec3to8

// File: rtl/cache_fill_fsm.sv
// Cache miss fill controller: latches the block base, streams eight word reads
// to memory and writes each returned word into the data array, tag on the last.
module cache_fill_fsm
    import cache_pkg::*;
#(
    parameter int WORDS = 8,
    parameter int AW    = 16,
    parameter int DW    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             miss_detected,
    input  logic [AW-1:0]    miss_address,
    input  logic [DW-1:0]    memory_data,
    input  logic             memory_data_valid,
    output logic             fsm_busy,
    output logic             mem_read,
    output logic [AW-1:0]    memory_address,
    output logic             write_data_array,
    output logic [WORDS-1:0] word_enable,
    output logic [DW-1:0]    fill_data,
    output logic             write_tag_array,
    output logic [AW-1:0]    fill_base
);

    fill_state_t   r_state;
    logic [3:0]    r_req_cnt;
    logic [2:0]    r_rcv_cnt;
    logic [AW-1:0] r_fill_base;

    logic          w_in_fill;
    logic          w_req_active;
    logic          w_accept;
    logic          w_last_word;
    logic [AW-1:0] w_base_mask;
    logic [AW-1:0] w_req_offset;
    logic [7:0]    w_onehot;

    assign w_base_mask  = {{(AW-BLOCK_OFFSET_BITS){1'b1}}, {BLOCK_OFFSET_BITS{1'b0}}};
    assign w_req_offset = {{(AW-5){1'b0}}, r_req_cnt, 1'b0};

    assign w_in_fill    = (r_state == FILL);
    assign w_req_active = w_in_fill && !r_req_cnt[3];
    assign w_accept     = w_in_fill && memory_data_valid;
    assign w_last_word  = w_accept && (r_rcv_cnt == 3'd7);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= IDLE;
            r_req_cnt   <= '0;
            r_rcv_cnt   <= '0;
            r_fill_base <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (miss_detected) begin
                        r_state     <= FILL;
                        r_fill_base <= miss_address & w_base_mask;
                        r_req_cnt   <= '0;
                        r_rcv_cnt   <= '0;
                    end
                end
                FILL: begin
                    if (w_req_active) begin
                        r_req_cnt <= r_req_cnt + 4'd1;
                    end
                    // rcv_cnt wraps to 0 exactly when the eighth word ends the fill
                    if (w_accept) begin
                        r_rcv_cnt <= r_rcv_cnt + 3'd1;
                        if (r_rcv_cnt == 3'd7) begin
                            r_state <= IDLE;
                        end
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    onehot_dec3to8 u_word_dec (
        .i_en     (w_accept),
        .i_sel    (r_rcv_cnt),
        .o_onehot (w_onehot)
    );

    assign fsm_busy         = w_in_fill;
    assign mem_read         = w_req_active;
    assign memory_address   = w_req_active ? (r_fill_base + w_req_offset) : '0;
    assign write_data_array = w_accept;
    assign word_enable      = w_onehot[WORDS-1:0];
    assign fill_data        = w_accept ? memory_data : '0;
    assign write_tag_array  = w_last_word;
    assign fill_base        = r_fill_base;

endmodule : cache_fill_fsm
